// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter: state encoding,
// widths and the round-robin pick helper.
package rr_mux4_arbiter_pkg;

    localparam int SEL_W   = 2;
    localparam int NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First set request scanning last+1, last+2, last+3, last (mod 4).
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   last);
        pick_t            p;
        logic [SEL_W-1:0] cand;
        p.found = 1'b0;
        p.idx   = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last + SEL_W'(k);
            if (!p.found && req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

    // One-hot grant vector for a requester index.
    function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_mux4_arbiter_mux4to1_sel.sv
// Plain combinational 4:1 single-bit mux steered by the arbiter's select.
// Gating with out_valid is left to the instantiating block.
module mux4to1_sel
    import rr_mux4_arbiter_pkg::*;
(
    input  logic             in0,
    input  logic             in1,
    input  logic             in2,
    input  logic             in3,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    // Route the selected data bit to the output.
    always_comb begin
        y = in0;
        case (sel)
            2'd0: y = in0;
            2'd1: y = in1;
            2'd2: y = in2;
            2'd3: y = in3;
            default: y = in0;
        endcase
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one 4:1 1-bit mux among four requesters.
// The owner keeps the grant for at most MAX_HOLD consecutive cycles; on
// release the next requester is picked in the same edge, so there is no
// idle gap between owners.
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               in0,
    input  logic               in1,
    input  logic               in2,
    input  logic               in3,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               out,
    output logic               out_valid
);

    // Hold count value at which the owner must give up the grant.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   hold_q;
    logic [SEL_W-1:0]   last_q;

    pick_t              pick_idle;
    pick_t              pick_rel;
    logic               keep_owner;
    logic               mux_y;

    // Candidate winners: from the last released owner when idle, and from
    // the current owner when it releases during a grant.
    always_comb begin
        pick_idle  = rr_pick(req, last_q);
        pick_rel   = rr_pick(req, sel_q);
        keep_owner = req[sel_q] && (hold_q < HOLD_LAST);
    end

    // Arbitration FSM with registered select, grant and valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            hold_q      <= '0;
            last_q      <= SEL_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_idle.found) begin
                        state_q     <= ST_GRANT;
                        sel_q       <= pick_idle.idx;
                        gnt_q       <= idx2onehot(pick_idle.idx);
                        out_valid_q <= 1'b1;
                        hold_q      <= '0;
                    end
                end
                ST_GRANT: begin
                    if (keep_owner) begin
                        hold_q <= hold_q + CNT_W'(1);
                    end else begin
                        last_q <= sel_q;
                        hold_q <= '0;
                        if (pick_rel.found) begin
                            sel_q <= pick_rel.idx;
                            gnt_q <= idx2onehot(pick_rel.idx);
                        end else begin
                            // Nobody requests: drop the grant, sel keeps its value.
                            state_q     <= ST_IDLE;
                            gnt_q       <= '0;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    gnt_q       <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    mux4to1_sel u_mux (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .sel (sel_q),
        .y   (mux_y)
    );

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out       = out_valid_q & mux_y;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: a MAX_HOLD=4 and a MAX_HOLD=1 instance share
// the same stimulus and are compared against a behavioural model each cycle.
module tb_rr_mux4_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] din = 4'b0000;

    logic [1:0] sel4, sel1;
    logic [3:0] gnt4, gnt1;
    logic       out4, out1, ov4, ov1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_mux4_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .req(req),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .sel(sel4), .gnt(gnt4), .out(out4), .out_valid(ov4)
    );

    rr_mux4_arbiter #(.MAX_HOLD(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .sel(sel1), .gnt(gnt1), .out(out1), .out_valid(ov1)
    );

    // Reference model: per instance, is someone served, who, for how many
    // cycles so far, and who was the last to give the grant away.
    int m_mh[2];
    int m_busy[2];
    int m_owner[2];
    int m_held[2];
    int m_last[2];

    function automatic int rr_next(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_busy[m]  = 0;
            m_owner[m] = 0;
            m_held[m]  = 0;
            m_last[m]  = 3;
        end
    endtask

    task automatic model_edge(input logic [3:0] r);
        int w;
        for (int m = 0; m < 2; m++) begin
            if (m_busy[m] == 0) begin
                w = rr_next(r, m_last[m]);
                if (w >= 0) begin
                    m_busy[m]  = 1;
                    m_owner[m] = w;
                    m_held[m]  = 1;
                end
            end else if (r[m_owner[m]] && m_held[m] < m_mh[m]) begin
                m_held[m] = m_held[m] + 1;
            end else begin
                m_last[m] = m_owner[m];
                w = rr_next(r, m_owner[m]);
                if (w >= 0) begin
                    m_owner[m] = w;
                    m_held[m]  = 1;
                end else begin
                    m_busy[m] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eg;
        logic [3:0] es;
        logic [3:0] ev;
        logic [3:0] eo;
        for (int m = 0; m < 2; m++) begin
            eg = (m_busy[m] != 0) ? (4'b0001 << m_owner[m]) : 4'b0000;
            es = 4'(m_owner[m]);
            ev = (m_busy[m] != 0) ? 4'd1 : 4'd0;
            eo = (m_busy[m] != 0) ? {3'b000, din[m_owner[m]]} : 4'd0;
            if (m == 0) begin
                chk({tag, ".h4.gnt"}, gnt4, eg);
                chk({tag, ".h4.sel"}, {2'b00, sel4}, es);
                chk({tag, ".h4.valid"}, {3'b000, ov4}, ev);
                chk({tag, ".h4.out"}, {3'b000, out4}, eo);
            end else begin
                chk({tag, ".h1.gnt"}, gnt1, eg);
                chk({tag, ".h1.sel"}, {2'b00, sel1}, es);
                chk({tag, ".h1.valid"}, {3'b000, ov1}, ev);
                chk({tag, ".h1.out"}, {3'b000, out1}, eo);
            end
        end
    endtask

    // Apply inputs, clock one edge, then compare just after it.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] d);
        req = r;
        din = d;
        @(posedge clk);
        model_edge(r);
        #1;
        check_model(tag);
    endtask

    // Assert reset between edges; outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model({tag, ".async"});
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_model({tag, ".held"});
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       ov;
        logic       out;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [3:0] r;
        logic [3:0] d;

        m_mh[0] = 4;
        m_mh[1] = 1;
        model_reset();

        // Single requester, then early release of owner 1 to waiting 3.
        tbl[0] = '{req: 4'b0100, din: 4'b0100, gnt: 4'b0100, sel: 2'd2, ov: 1'b1, out: 1'b1};
        tbl[1] = '{req: 4'b0000, din: 4'b0100, gnt: 4'b0000, sel: 2'd2, ov: 1'b0, out: 1'b0};
        tbl[2] = '{req: 4'b0010, din: 4'b0000, gnt: 4'b0010, sel: 2'd1, ov: 1'b1, out: 1'b0};
        tbl[3] = '{req: 4'b1010, din: 4'b0010, gnt: 4'b0010, sel: 2'd1, ov: 1'b1, out: 1'b1};
        tbl[4] = '{req: 4'b1000, din: 4'b1000, gnt: 4'b1000, sel: 2'd3, ov: 1'b1, out: 1'b1};
        tbl[5] = '{req: 4'b1000, din: 4'b0000, gnt: 4'b1000, sel: 2'd3, ov: 1'b1, out: 1'b0};
        tbl[6] = '{req: 4'b0000, din: 4'b0000, gnt: 4'b0000, sel: 2'd3, ov: 1'b0, out: 1'b0};

        #1;
        do_reset("init");

        for (int i = 0; i < 7; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].req, tbl[i].din);
            chk($sformatf("tbl%0d.gnt", i), gnt4, tbl[i].gnt);
            chk($sformatf("tbl%0d.sel", i), {2'b00, sel4}, {2'b00, tbl[i].sel});
            chk($sformatf("tbl%0d.valid", i), {3'b000, ov4}, {3'b000, tbl[i].ov});
            chk($sformatf("tbl%0d.out", i), {3'b000, out4}, {3'b000, tbl[i].out});
        end

        // Reset asserted in the middle of a grant.
        step("pre_rst", 4'b0110, 4'b1111);
        step("pre_rst", 4'b0110, 4'b1111);
        do_reset("midgrant");
        chk("midgrant.out_zero", {3'b000, out4}, 4'd0);

        // Full rotation with all requesting: 4 cycles each vs. every cycle.
        for (int k = 0; k < 20; k++) begin
            d = 4'($urandom);
            step("rot", 4'b1111, d);
            chk($sformatf("rot%0d.h4owner", k), gnt4, 4'b0001 << ((k / 4) % 4));
            chk($sformatf("rot%0d.h1owner", k), gnt1, 4'b0001 << (k % 4));
        end

        // Lone hog keeps the grant indefinitely.
        do_reset("hog");
        for (int k = 0; k < 10; k++) begin
            step("hog", 4'b0001, 4'($urandom));
            chk($sformatf("hog%0d.gnt", k), gnt4, 4'b0001);
            chk($sformatf("hog%0d.valid", k), {3'b000, ov4}, 4'd1);
        end

        // Per-cycle alternation on the MAX_HOLD=1 instance.
        do_reset("alt");
        for (int k = 0; k < 8; k++) begin
            d = 4'($urandom);
            step("alt", 4'b1010, d);
            chk($sformatf("alt%0d.gnt", k), gnt1, (k % 2 == 0) ? 4'b0010 : 4'b1000);
            chk($sformatf("alt%0d.out", k), {3'b000, out1},
                {3'b000, (k % 2 == 0) ? d[1] : d[3]});
        end

        // Randomised traffic with requests often held across cycles.
        do_reset("rnd");
        r = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) r = 4'($urandom);
            if ($urandom_range(0, 7) == 0) r = 4'b0000;
            step("rnd", r, 4'($urandom));
            if (k % 131 == 130) do_reset("rnd_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
